// File: rtl/bpu_pkg.sv
// bpu_pkg: shared BPU types, saturating-counter constants and update function
package bpu_pkg;
  localparam int SAT_TABLE_SIZE = 16;
  localparam int IDX_W = $clog2(SAT_TABLE_SIZE);
  typedef logic [1:0] sat_cnt_t;
  localparam sat_cnt_t SAT_STRONG_NT = 2'b00;
  localparam sat_cnt_t SAT_WEAK_T = 2'b10;
  localparam sat_cnt_t SAT_STRONG_T = 2'b11;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upht_res_t;
  function automatic sat_cnt_t sat_next(sat_cnt_t cnt, logic taken);
    return taken ? (cnt == SAT_STRONG_T ? SAT_STRONG_T : cnt + 2'd1)
                 : (cnt == SAT_STRONG_NT ? SAT_STRONG_NT : cnt - 2'd1);
  endfunction
endpackage

// File: rtl/upht_updater_if.sv
// upht_updater_if: resolve handshake plus uPHT read/write ports
interface upht_updater_if;
  import bpu_pkg::*;
  logic             i_res_vld;
  logic             o_res_rdy;
  logic [IDX_W-1:0] i_res_idx;
  logic             i_res_taken;
  logic             o_uPhtRead_vld;
  logic [IDX_W-1:0] o_uPhtRd_addr;
  sat_cnt_t         i_uPhtRd_Cnt;
  logic             o_uPhtWrite_vld;
  logic [IDX_W-1:0] o_uPhtWr_addr;
  sat_cnt_t         o_commit_Cnt;
  modport master (
    output i_res_vld, i_res_idx, i_res_taken, i_uPhtRd_Cnt,
    input  o_res_rdy, o_uPhtRead_vld, o_uPhtRd_addr, o_uPhtWrite_vld, o_uPhtWr_addr, o_commit_Cnt
  );
  modport slave (
    input  i_res_vld, i_res_idx, i_res_taken, i_uPhtRd_Cnt,
    output o_res_rdy, o_uPhtRead_vld, o_uPhtRd_addr, o_uPhtWrite_vld, o_uPhtWr_addr, o_commit_Cnt
  );
endinterface

// File: rtl/bpu_sync_fifo.sv
// bpu_sync_fifo: synchronous FIFO with valid/ready push and pop-when-non-empty
module bpu_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic full, do_push, do_pop;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign push_rdy = ~full;
  assign do_push = push_vld & ~full;
  assign do_pop = pop & ~empty;
  assign pop_data = mem[rp[AW-1:0]];
  // pointer update; a full FIFO refuses pushes even when popping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/upht_updater.sv
// upht_updater: buffers resolved branches and read-modify-writes uPHT counters
module upht_updater
  import bpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  upht_updater_if.slave  bus,
  output logic           o_uPht_enable,
  output logic           o_busy
);
  upht_res_t res_in, head, s1, s2;
  logic s1_vld, s2_vld, empty;
  sat_cnt_t cnt_in, nxt, s2_cnt;
  assign res_in = '{idx: bus.i_res_idx, taken: bus.i_res_taken};
  bpu_sync_fifo #(.W($bits(upht_res_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push_vld (bus.i_res_vld),
    .push_rdy (bus.o_res_rdy),
    .push_data(res_in),
    .pop      (1'b1),
    .pop_data (head),
    .empty    (empty)
  );
  // the write landing this edge is not yet visible in the uPHT, so forward it
  always_comb begin
    cnt_in = (s2_vld && s2.idx == s1.idx) ? s2_cnt : bus.i_uPhtRd_Cnt;
    nxt = sat_next(cnt_in, s1.taken);
  end
  // S1 takes the FIFO head every non-empty cycle; payloads only move with valid data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld <= 1'b0;
      s1 <= '0;
      s2_vld <= 1'b0;
      s2 <= '0;
      s2_cnt <= SAT_STRONG_NT;
    end else begin
      s1_vld <= ~empty;
      if (!empty) s1 <= head;
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2 <= s1;
        s2_cnt <= nxt;
      end
    end
  end
  assign bus.o_uPhtRead_vld = s1_vld;
  assign bus.o_uPhtRd_addr = s1.idx;
  assign bus.o_uPhtWrite_vld = s2_vld;
  assign bus.o_uPhtWr_addr = s2.idx;
  assign bus.o_commit_Cnt = s2_cnt;
  assign o_uPht_enable = ~i_rst;
  assign o_busy = ~empty | s1_vld | s2_vld;
endmodule

// File: tb/tb_upht_updater.sv
// tb_upht_updater: directed checks of the uPHT update engine and its FIFO
module tb_upht_updater;
  import bpu_pkg::*;
  logic clk, rst, en, busy;
  int tests = 0, fails = 0, cyc = 0;
  sat_cnt_t upht [SAT_TABLE_SIZE];
  logic pre_we;
  logic [3:0] pre_addr;
  sat_cnt_t pre_val;
  logic [5:0] wlog [$];
  int wcyc [$];
  logic f_push, f_rdy, f_pop, f_empty;
  logic [7:0] f_din, f_dout;

  upht_updater_if bus ();
  upht_updater #(.FIFO_DEPTH(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus), .o_uPht_enable(en), .o_busy(busy));
  bpu_sync_fifo #(.W(8), .DEPTH(4)) u_ff (.clk(clk), .rst(rst), .push_vld(f_push), .push_rdy(f_rdy),
    .push_data(f_din), .pop(f_pop), .pop_data(f_dout), .empty(f_empty));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  assign bus.i_uPhtRd_Cnt = upht[bus.o_uPhtRd_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) upht[pre_addr] <= pre_val;
    else if (bus.o_uPhtWrite_vld) upht[bus.o_uPhtWr_addr] <= bus.o_commit_Cnt;
  end
  always @(negedge clk) if (bus.o_uPhtWrite_vld) begin
    wlog.push_back({bus.o_uPhtWr_addr, bus.o_commit_Cnt});
    wcyc.push_back(cyc);
  end

  task automatic preset(input logic [3:0] a, input sat_cnt_t v);
    pre_we = 1; pre_addr = a; pre_val = v;
    @(posedge clk); #1 pre_we = 0;
  endtask
  task automatic send(input logic [3:0] idx, input logic tk);
    bus.i_res_vld = 1; bus.i_res_idx = idx; bus.i_res_taken = tk;
    @(posedge clk); #1 bus.i_res_vld = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1 n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL drain_timeout: busy still %b after %0d cycles, want 0", busy, n);
    end
  endtask
  task automatic check_log(input string nm, input logic [5:0] e [4]);
    tests++;
    if (wlog.size() != 4) begin fails++; $display("FAIL %s_count: got %0d writes want 4", nm, wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wlog[i] !== e[i]) begin fails++; $display("FAIL %s_w%0d: got idx/cnt %h want %h", nm, i, wlog[i], e[i]); end
    end
  endtask

  task automatic test_reset();
    rst = 1; bus.i_res_vld = 0; bus.i_res_idx = 0; bus.i_res_taken = 0; pre_we = 0;
    f_push = 0; f_pop = 0; f_din = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.o_res_rdy, bus.o_uPhtRead_vld, bus.o_uPhtWrite_vld, busy, en} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctl: got rdy/rd/wr/busy/en %b want 10000",
        {bus.o_res_rdy, bus.o_uPhtRead_vld, bus.o_uPhtWrite_vld, busy, en});
    end
    tests++;
    if ({bus.o_uPhtRd_addr, bus.o_uPhtWr_addr, bus.o_commit_Cnt} !== 10'h0) begin
      fails++; $display("FAIL reset_data: got %h want 000", {bus.o_uPhtRd_addr, bus.o_uPhtWr_addr, bus.o_commit_Cnt});
    end
    rst = 0;
    @(posedge clk); #1;
    tests++;
    if (en !== 1'b1 || bus.o_res_rdy !== 1'b1) begin fails++; $display("FAIL post_reset: got en %b rdy %b want 1 1", en, bus.o_res_rdy); end
  endtask

  task automatic test_single();
    preset(5, 2'b10);
    send(5, 1);
    tests++;
    if (busy !== 1 || bus.o_uPhtRead_vld !== 0) begin fails++; $display("FAIL single_T: got busy %b rd %b want 1 0", busy, bus.o_uPhtRead_vld); end
    @(posedge clk); #1;
    tests++;
    if (bus.o_uPhtRead_vld !== 1 || bus.o_uPhtRd_addr !== 4'd5) begin
      fails++; $display("FAIL single_read: got vld %b addr %0d want 1 5", bus.o_uPhtRead_vld, bus.o_uPhtRd_addr);
    end
    @(posedge clk); #1;
    tests++;
    if ({bus.o_uPhtWrite_vld, bus.o_uPhtWr_addr, bus.o_commit_Cnt} !== {1'b1, 4'd5, 2'b11}) begin
      fails++; $display("FAIL single_write: got vld %b addr %0d cnt %b want 1 5 11", bus.o_uPhtWrite_vld, bus.o_uPhtWr_addr, bus.o_commit_Cnt);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 0 || bus.o_uPhtWrite_vld !== 0 || upht[5] !== 2'b11) begin
      fails++; $display("FAIL single_done: got busy %b wr %b upht %b want 0 0 11", busy, bus.o_uPhtWrite_vld, upht[5]);
    end
  endtask

  task automatic test_back_to_back();
    preset(3, 2'b00);
    wlog.delete(); wcyc.delete();
    repeat (4) send(3, 1);
    drain();
    check_log("b2b", '{{4'd3, 2'b01}, {4'd3, 2'b10}, {4'd3, 2'b11}, {4'd3, 2'b11}});
    tests++;
    if (wcyc.size() != 4 || wcyc[3] - wcyc[0] != 3) begin fails++; $display("FAIL b2b_spacing: writes not in 4 consecutive cycles (%0d)", wcyc.size()); end
  endtask

  task automatic test_not_taken();
    preset(7, 2'b01);
    wlog.delete();
    send(7, 0); send(7, 0);
    drain();
    tests++;
    if (wlog.size() != 2 || wlog[0] !== {4'd7, 2'b00} || wlog[1] !== {4'd7, 2'b00}) begin
      fails++; $display("FAIL not_taken: got %0d writes first %h want 2 writes of 1c", wlog.size(), wlog[0]);
    end
  endtask

  task automatic test_alternate();
    preset(1, 2'b10); preset(2, 2'b10);
    wlog.delete();
    send(1, 1); send(2, 1); send(1, 1); send(2, 1);
    drain();
    check_log("alt", '{{4'd1, 2'b11}, {4'd2, 2'b11}, {4'd1, 2'b11}, {4'd2, 2'b11}});
  endtask

  task automatic test_stream();
    int drops = 0;
    for (int i = 0; i < 8; i++) preset(4'(8 + i), 2'b10);
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus.o_res_rdy !== 1'b1) drops++;
      send(4'(8 + i), i[0]);
    end
    drain();
    tests++;
    if (drops != 0) begin fails++; $display("FAIL stream_rdy: rdy low %0d times want 0", drops); end
    tests++;
    if (wlog.size() != 8) begin fails++; $display("FAIL stream_count: got %0d writes want 8", wlog.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (wlog[i] !== {4'(8 + i), i[0] ? 2'b11 : 2'b01}) begin
        fails++; $display("FAIL stream_w%0d: got %h want %h", i, wlog[i], {4'(8 + i), i[0] ? 2'b11 : 2'b01});
      end
    end
  endtask

  task automatic test_full();
    f_pop = 0;
    for (int i = 0; i < 4; i++) begin
      f_push = 1; f_din = 8'(8'hA0 + i);
      @(posedge clk); #1;
    end
    f_push = 0;
    tests++;
    if (f_rdy !== 0 || f_empty !== 0) begin fails++; $display("FAIL full_rdy: got rdy %b empty %b want 0 0", f_rdy, f_empty); end
    f_push = 1; f_pop = 1; f_din = 8'hEE;
    @(posedge clk); #1;
    f_push = 0;
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (f_dout !== 8'(8'hA0 + i)) begin fails++; $display("FAIL full_pop%0d: got %h want %h", i, f_dout, 8'(8'hA0 + i)); end
      @(posedge clk); #1;
    end
    tests++;
    if (f_empty !== 1) begin fails++; $display("FAIL full_refused: got empty %b want 1 (push while full must be dropped)", f_empty); end
    f_pop = 0;
  endtask

  task automatic test_reset_mid();
    preset(6, 2'b00);
    wlog.delete();
    send(6, 1); send(6, 1); send(6, 1);
    rst = 1; #1;
    tests++;
    if (bus.o_uPhtWrite_vld !== 0 || bus.o_uPhtRead_vld !== 0 || busy !== 0 || en !== 0) begin
      fails++; $display("FAIL mid_reset: got wr %b rd %b busy %b en %b want 0 0 0 0", bus.o_uPhtWrite_vld, bus.o_uPhtRead_vld, busy, en);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (wlog.size() != 0 || busy !== 0 || bus.o_res_rdy !== 1 || upht[6] !== 2'b00) begin
      fails++; $display("FAIL mid_after: got writes %0d busy %b rdy %b upht %b want 0 0 1 00", wlog.size(), busy, bus.o_res_rdy, upht[6]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_not_taken();
    test_alternate();
    test_stream();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
